// File: rtl/timer_ctrl.sv
// MM:SS stopwatch/timer sequencer: owns the count and 1 Hz prescaler; all outputs registered.
// One event acts per cycle: softrst > mode change > stop > start > inc_min > inc_sec > tick.
module timer_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int MAX_MIN = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_p,
   input  logic       stop_p,
   input  logic       softrst_p,
   input  logic       inc_min_p,
   input  logic       inc_sec_p,
   input  logic       mode_sw,
   input  logic       inc_sw,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [2:0] state,
   output logic       running,
   output logic       expired
);

   localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   P_LAST  = PW'(CLK_HZ - 1);
   localparam logic [7:0]      MIN_MOD = 8'(MAX_MIN + 1);
   localparam logic [6:0]      MIN_TOP = 7'(MAX_MIN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [6:0]      r_min;
   logic [5:0]      r_sec;
   logic            r_mode;

   logic            w_edit;
   logic            w_mode_chg;
   logic            w_clear;
   logic            w_start_ok;
   logic            w_tick;
   logic            w_zero;
   logic [6:0]      w_step;
   logic [6:0]      w_min_inc;
   logic [5:0]      w_sec_inc;
   logic            w_up_sat;
   logic [6:0]      w_up_min;
   logic [5:0]      w_up_sec;
   logic [6:0]      w_dn_min;
   logic [5:0]      w_dn_sec;
   logic            w_dn_zero;

   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   always_comb begin
      w_edit     = (r_state == S_IDLE) || (r_state == S_PAUSE);
      // r_mode only follows mode_sw while editable, so a flip during RUN/DONE stays pending
      w_mode_chg = w_edit && (mode_sw != r_mode);
      w_clear    = softrst_p || w_mode_chg || (stop_p && (r_state == S_DONE));
      w_zero     = (r_min == 7'd0) && (r_sec == 6'd0);
      w_start_ok = w_edit && !(r_mode && w_zero);
      w_tick     = (r_state == S_RUN) && (r_presc == P_LAST);

      w_step     = inc_sw ? 7'd10 : 7'd1;
      w_min_inc  = 7'(({1'b0, r_min} + {1'b0, w_step}) % MIN_MOD);
      w_sec_inc  = 6'(({1'b0, r_sec} + w_step) % 7'd60);

      w_up_sat   = (r_min == MIN_TOP) && (r_sec == 6'd59);
      w_up_sec   = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
      w_up_min   = (r_sec == 6'd59) ? r_min + 7'd1 : r_min;

      w_dn_sec   = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
      w_dn_min   = (r_sec == 6'd0) ? r_min - 7'd1 : r_min;
      w_dn_zero  = (w_dn_min == 7'd0) && (w_dn_sec == 6'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_min   <= '0;
         r_sec   <= '0;
         r_mode  <= 1'b0;
         min_bcd <= '0;
         sec_bcd <= '0;
         running <= 1'b0;
         expired <= 1'b0;
      end else if (w_clear) begin
         if (!softrst_p && w_mode_chg)
            r_mode <= mode_sw;
         r_state <= S_IDLE;
         r_presc <= '0;
         r_min   <= '0;
         r_sec   <= '0;
         min_bcd <= '0;
         sec_bcd <= '0;
         running <= 1'b0;
         expired <= 1'b0;
      end else if (stop_p && (r_state == S_RUN)) begin
         r_state <= S_PAUSE;
         running <= 1'b0;
      end else if (start_p && w_start_ok) begin
         // resuming from PAUSE keeps the partial second
         if (r_state == S_IDLE)
            r_presc <= '0;
         r_state <= S_RUN;
         running <= 1'b1;
      end else if (inc_min_p && w_edit) begin
         r_min   <= w_min_inc;
         min_bcd <= to_bcd(w_min_inc);
      end else if (inc_sec_p && w_edit) begin
         r_sec   <= w_sec_inc;
         sec_bcd <= to_bcd({1'b0, w_sec_inc});
      end else if (r_state == S_RUN) begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            if (!r_mode) begin
               if (w_up_sat) begin
                  r_state <= S_DONE;
                  running <= 1'b0;
                  expired <= 1'b1;
               end else begin
                  r_min   <= w_up_min;
                  r_sec   <= w_up_sec;
                  min_bcd <= to_bcd(w_up_min);
                  sec_bcd <= to_bcd({1'b0, w_up_sec});
               end
            end else if (w_zero) begin
               r_state <= S_DONE;
               running <= 1'b0;
               expired <= 1'b1;
            end else begin
               r_min   <= w_dn_min;
               r_sec   <= w_dn_sec;
               min_bcd <= to_bcd(w_dn_min);
               sec_bcd <= to_bcd({1'b0, w_dn_sec});
               if (w_dn_zero) begin
                  r_state <= S_DONE;
                  running <= 1'b0;
                  expired <= 1'b1;
               end
            end
         end
      end
   end

   assign state = {1'b0, r_state};

endmodule

// File: tb/tb_timer_ctrl.sv
// Vector-table bench for timer_ctrl with CLK_HZ=10, MAX_MIN=99; expectations queued at drive time.
module tb_timer_ctrl;

   localparam int CLK_HZ = 10;

   localparam logic [4:0] P_NONE  = 5'b00000;
   localparam logic [4:0] P_ISEC  = 5'b00001;
   localparam logic [4:0] P_IMIN  = 5'b00010;
   localparam logic [4:0] P_START = 5'b00100;
   localparam logic [4:0] P_STOP  = 5'b01000;
   localparam logic [4:0] P_SRST  = 5'b10000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_p = 1'b0, stop_p = 1'b0, softrst_p = 1'b0;
   logic       inc_min_p = 1'b0, inc_sec_p = 1'b0;
   logic       mode_sw = 1'b0, inc_sw = 1'b0;
   logic [7:0] min_bcd, sec_bcd;
   logic [2:0] state;
   logic       running, expired;

   timer_ctrl #(.CLK_HZ(CLK_HZ), .MAX_MIN(99)) dut (
      .clk(clk), .rst(rst),
      .start_p(start_p), .stop_p(stop_p), .softrst_p(softrst_p),
      .inc_min_p(inc_min_p), .inc_sec_p(inc_sec_p),
      .mode_sw(mode_sw), .inc_sw(inc_sw),
      .min_bcd(min_bcd), .sec_bcd(sec_bcd), .state(state),
      .running(running), .expired(expired)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] pulse;
      logic       mode;
      logic       incsw;
      int         waitc;
      logic [7:0] emin;
      logic [7:0] esec;
      logic [2:0] est;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] emin;
      logic [7:0] esec;
      logic [2:0] est;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   n_a;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic void add(input string n, input logic [4:0] p, input logic m, input logic i,
                               input int w, input int em, input int es, input logic [2:0] st);
      vec_t v;
      v.name = n; v.pulse = p; v.mode = m; v.incsw = i; v.waitc = w;
      v.emin = bcd(em); v.esec = bcd(es); v.est = st;
      vecs.push_back(v);
   endfunction

   task automatic expect_now(input string n, input logic [7:0] em, input logic [7:0] es, input logic [2:0] st);
      exp_t e;
      e.name = n; e.emin = em; e.esec = es; e.est = st;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (min_bcd !== e.emin || sec_bcd !== e.esec || state !== e.est ||
          running !== (e.est == 3'd1) || expired !== (e.est == 3'd3)) begin
         failures++;
         $display("FAIL %s: got min=%h sec=%h state=%0d running=%b expired=%b, want min=%h sec=%h state=%0d",
                  e.name, min_bcd, sec_bcd, state, running, expired, e.emin, e.esec, e.est);
      end
   endtask

   task automatic apply(input vec_t v);
      mode_sw = v.mode;
      inc_sw  = v.incsw;
      {softrst_p, stop_p, start_p, inc_min_p, inc_sec_p} = v.pulse;
      expect_now(v.name, v.emin, v.esec, v.est);
      @(negedge clk);
      {softrst_p, stop_p, start_p, inc_min_p, inc_sec_p} = P_NONE;
      repeat (v.waitc) @(negedge clk);
      check_out();
   endtask

   initial begin
      // first run, interrupted by an asynchronous reset
      add("sw_start",  P_START, 0, 0, 0, 0, 0, 3'd1);
      add("sw_pre9",   P_NONE,  0, 0, 8, 0, 0, 3'd1);
      add("sw_tick1",  P_NONE,  0, 0, 0, 0, 1, 3'd1);
      n_a = vecs.size();

      for (int k = 1; k <= 6; k++) add("sec_x10", P_ISEC, 0, 1, 0, 0, (k * 10) % 60, 3'd0);
      for (int k = 1; k <= 9; k++) add("min_x10", P_IMIN, 0, 1, 0, k * 10, 0, 3'd0);
      for (int k = 1; k <= 9; k++) add("min_x1",  P_IMIN, 0, 0, 0, 90 + k, 0, 3'd0);
      add("min_wrap99", P_IMIN, 0, 0, 0, 0, 0, 3'd0);
      for (int k = 1; k <= 5; k++) add("sec_x1",  P_ISEC, 0, 0, 0, 0, k, 3'd0);
      for (int k = 1; k <= 5; k++) add("sec_x10b", P_ISEC, 0, 1, 0, 0, 5 + 10 * k, 3'd0);
      add("sec_55p10", P_ISEC, 0, 1, 0, 0, 5, 3'd0);
      for (int k = 1; k <= 5; k++) add("sec_x10c", P_ISEC, 0, 1, 0, 0, 5 + 10 * k, 3'd0);
      for (int k = 1; k <= 4; k++) add("sec_x1b", P_ISEC, 0, 0, 0, 0, 55 + k, 3'd0);
      add("sec_59p1",       P_ISEC,          0, 0, 0, 0, 0, 3'd0);
      add("imin_over_isec", P_IMIN | P_ISEC, 0, 0, 0, 1, 0, 3'd0);
      add("softrst_start",  P_SRST | P_START, 0, 0, 0, 0, 0, 3'd0);

      add("mode_to_timer",  P_NONE,  1, 0, 0, 0, 0, 3'd0);
      add("tmr_start_zero", P_START, 1, 0, 0, 0, 0, 3'd0);
      add("tmr_set_min",    P_IMIN,  1, 0, 0, 1, 0, 3'd0);
      add("tmr_set_s1",     P_ISEC,  1, 0, 0, 1, 1, 3'd0);
      add("tmr_set_s2",     P_ISEC,  1, 0, 0, 1, 2, 3'd0);
      add("tmr_start",      P_START, 1, 0, 0, 1, 2, 3'd1);
      add("tmr_pre",        P_NONE,  1, 0, 8, 1, 2, 3'd1);
      add("tmr_tick1",      P_NONE,  1, 0, 0, 1, 1, 3'd1);
      add("tmr_3ticks",     P_NONE,  1, 0, 19, 0, 59, 3'd1);
      add("tmr_0001",       P_NONE,  1, 0, 579, 0, 1, 3'd1);
      add("tmr_done",       P_NONE,  1, 0, 9, 0, 0, 3'd3);
      add("done_start",     P_START, 1, 0, 0, 0, 0, 3'd3);
      add("done_inc",       P_IMIN,  1, 0, 0, 0, 0, 3'd3);
      add("done_stop",      P_STOP,  1, 0, 0, 0, 0, 3'd0);

      add("mode_to_sw", P_NONE, 0, 0, 0, 0, 0, 3'd0);
      for (int k = 1; k <= 5; k++) add("sw_set_s10", P_ISEC, 0, 1, 0, 0, 10 * k, 3'd0);
      for (int k = 1; k <= 8; k++) add("sw_set_s1",  P_ISEC, 0, 0, 0, 0, 50 + k, 3'd0);
      add("sw_start58", P_START, 0, 0, 0, 0, 58, 3'd1);
      add("sw_59",      P_NONE,  0, 0, 9, 0, 59, 3'd1);
      add("sw_carry",   P_NONE,  0, 0, 9, 1, 0, 3'd1);
      add("sw_pause",   P_STOP,  0, 0, 0, 1, 0, 3'd2);
      for (int k = 1; k <= 9; k++) add("pause_min10", P_IMIN, 0, 1, 0, 1 + 10 * k, 0, 3'd2);
      for (int k = 1; k <= 8; k++) add("pause_min1",  P_IMIN, 0, 0, 0, 91 + k, 0, 3'd2);
      for (int k = 1; k <= 5; k++) add("pause_s10",   P_ISEC, 0, 1, 0, 99, 10 * k, 3'd2);
      for (int k = 1; k <= 8; k++) add("pause_s1",    P_ISEC, 0, 0, 0, 99, 50 + k, 3'd2);
      add("sw_resume",  P_START, 0, 0, 0, 99, 58, 3'd1);
      add("sw_9959",    P_NONE,  0, 0, 9, 99, 59, 3'd1);
      add("sw_sat",     P_NONE,  0, 0, 9, 99, 59, 3'd3);
      add("sat_stop",   P_STOP,  0, 0, 0, 0, 0, 3'd0);

      add("p_start",    P_START, 0, 0, 0, 0, 0, 3'd1);
      add("p_run6",     P_NONE,  0, 0, 5, 0, 0, 3'd1);
      add("p_stop6",    P_STOP,  0, 0, 0, 0, 0, 3'd2);
      add("p_frozen",   P_NONE,  0, 0, 4, 0, 0, 3'd2);
      add("p_resume",   P_START, 0, 0, 0, 0, 0, 3'd1);
      add("p_pre",      P_NONE,  0, 0, 2, 0, 0, 3'd1);
      add("p_tick4",    P_NONE,  0, 0, 0, 0, 1, 3'd1);
      add("p_pre9",     P_NONE,  0, 0, 8, 0, 1, 3'd1);
      add("stop_on_tick", P_STOP, 0, 0, 0, 0, 1, 3'd2);
      add("srst_start_p", P_SRST | P_START, 0, 0, 0, 0, 0, 3'd0);

      add("m_start",         P_START, 0, 0, 0, 0, 0, 3'd1);
      add("m_toggle_run",    P_NONE,  1, 0, 0, 0, 0, 3'd1);
      add("m_still_up",      P_NONE,  1, 0, 8, 0, 1, 3'd1);
      add("m_stop",          P_STOP,  1, 0, 0, 0, 1, 3'd2);
      add("m_pause_clear",   P_NONE,  1, 0, 0, 0, 0, 3'd0);
      add("m_tmr_zero_start", P_START, 1, 0, 0, 0, 0, 3'd0);

      repeat (2) @(negedge clk);
      expect_now("reset", 8'h00, 8'h00, 3'd0);
      check_out();
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < n_a; i++) apply(vecs[i]);

      // mid-RUN reset must clear outputs without waiting for a clock edge
      #2 rst = 1'b0;
      #1;
      expect_now("async_reset", 8'h00, 8'h00, 3'd0);
      check_out();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = n_a; i < vecs.size(); i++) apply(vecs[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
